// File: rtl/pcs_rx_sync_ctrl.sv
// 8b10b receive code-group synchronization: comma acquisition plus error-level
// hysteresis for declaring and dropping link sync, with a disparity re-seed on loss.
module pcs_rx_sync_ctrl #(
  parameter int unsigned COMMAS_TO_SYNC = 3,
  parameter int unsigned GOOD_TO_HEAL   = 4,
  parameter int unsigned ERRS_TO_LOSE   = 4
) (
  input  logic       rbc,
  input  logic       aresetn,
  input  logic       cg_valid,
  input  logic       signal_detect,
  input  logic       is_comma,
  input  logic       is_data,
  input  logic       code_err,
  input  logic       rd_err,
  output logic       sync_ok,
  output logic       rx_even,
  output logic       rd_resync,
  output logic [2:0] state,
  output logic [2:0] err_level,
  output logic [7:0] loss_cnt
);

  typedef enum logic [1:0] {
    LOS  = 2'd0,
    CDET = 2'd1,
    ACQ  = 2'd2,
    SYNC = 2'd3
  } sync_state_e;

  localparam logic [2:0] COMMAS_LIM = 3'(COMMAS_TO_SYNC);
  localparam logic [3:0] HEAL_LIM   = 4'(GOOD_TO_HEAL - 1);
  localparam logic [2:0] LOSE_LIM   = 3'(ERRS_TO_LOSE);

  sync_state_e state_q, state_d;
  logic [2:0]  comma_cnt_q, comma_cnt_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic [2:0]  err_level_q, err_level_d;
  logic [7:0]  loss_cnt_q, loss_cnt_d;
  logic        rx_even_q, rx_even_d;
  logic        rd_resync_q, rd_resync_d;
  logic        sync_ok_q;
  logic        cg_bad;
  logic [2:0]  err_inc;

  // rx_even_q marks that the previous group sat on an even position, so a comma
  // seen while it is set is misaligned.
  assign cg_bad  = code_err | rd_err | (is_comma & rx_even_q);
  assign err_inc = err_level_q + 3'd1;

  always_comb begin
    // NOTE: every next-state signal gets its default first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    good_cnt_d  = good_cnt_q;
    err_level_d = err_level_q;
    loss_cnt_d  = loss_cnt_q;
    rx_even_d   = rx_even_q;
    rd_resync_d = 1'b0;

    if (!signal_detect && (state_q != LOS)) begin
      state_d = LOS;
    end else if (cg_valid) begin
      rx_even_d = ~rx_even_q;
      unique case (state_q)
        LOS: begin
          if (is_comma) begin
            state_d     = CDET;
            comma_cnt_d = 3'd1;
            rx_even_d   = 1'b1;
          end
        end
        CDET: begin
          if (is_data && !cg_bad) begin
            state_d = (comma_cnt_q == COMMAS_LIM) ? SYNC : ACQ;
          end else begin
            state_d = LOS;
          end
        end
        ACQ: begin
          if (cg_bad) begin
            state_d = LOS;
          end else if (is_comma && !rx_even_q) begin
            state_d     = CDET;
            comma_cnt_d = comma_cnt_q + 3'd1;
            rx_even_d   = 1'b1;
          end
        end
        SYNC: begin
          if (cg_bad) begin
            good_cnt_d  = 4'd0;
            err_level_d = err_inc;
            if (err_inc == LOSE_LIM) state_d = LOS;
          end else if (err_level_q != 3'd0) begin
            if (good_cnt_q == HEAL_LIM) begin
              err_level_d = err_level_q - 3'd1;
              good_cnt_d  = 4'd0;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end
        end
        default: state_d = LOS;
      endcase
    end

    // Any entry into LOS is a loss event; reset itself never passes through here.
    if ((state_d == LOS) && (state_q != LOS)) begin
      rd_resync_d = 1'b1;
      loss_cnt_d  = (loss_cnt_q == 8'hFF) ? loss_cnt_q : loss_cnt_q + 8'd1;
      comma_cnt_d = 3'd0;
      good_cnt_d  = 4'd0;
      err_level_d = 3'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge rbc or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= LOS;
      comma_cnt_q <= 3'd0;
      good_cnt_q  <= 4'd0;
      err_level_q <= 3'd0;
      loss_cnt_q  <= 8'd0;
      rx_even_q   <= 1'b0;
      rd_resync_q <= 1'b0;
      sync_ok_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      good_cnt_q  <= good_cnt_d;
      err_level_q <= err_level_d;
      loss_cnt_q  <= loss_cnt_d;
      rx_even_q   <= rx_even_d;
      rd_resync_q <= rd_resync_d;
      sync_ok_q   <= (state_d == SYNC);
    end
  end

  assign sync_ok   = sync_ok_q;
  assign rx_even   = rx_even_q;
  assign rd_resync = rd_resync_q;
  assign state     = {1'b0, state_q};
  assign err_level = err_level_q;
  assign loss_cnt  = loss_cnt_q;

endmodule

// File: tb/tb_pcs_rx_sync_ctrl.sv
// Self-checking bench for pcs_rx_sync_ctrl: directed scenarios with fixed expectations
// and a randomized stream compared against a behavioural model of the sync rules.
module tb_pcs_rx_sync_ctrl;

  localparam int COMMAS = 3;
  localparam int GOOD   = 4;
  localparam int ERRS   = 4;
  localparam int S_LOS  = 0;
  localparam int S_CDET = 1;
  localparam int S_ACQ  = 2;
  localparam int S_SYNC = 3;

  logic       rbc = 1'b0;
  logic       aresetn;
  logic       cg_valid, signal_detect, is_comma, is_data, code_err, rd_err;
  logic       sync_ok, rx_even, rd_resync;
  logic [2:0] state, err_level;
  logic [7:0] loss_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_state, m_comma, m_good, m_err, m_loss;
  bit m_rx_even, m_resync;

  pcs_rx_sync_ctrl #(
    .COMMAS_TO_SYNC(COMMAS),
    .GOOD_TO_HEAL  (GOOD),
    .ERRS_TO_LOSE  (ERRS)
  ) dut (
    .rbc          (rbc),
    .aresetn      (aresetn),
    .cg_valid     (cg_valid),
    .signal_detect(signal_detect),
    .is_comma     (is_comma),
    .is_data      (is_data),
    .code_err     (code_err),
    .rd_err       (rd_err),
    .sync_ok      (sync_ok),
    .rx_even      (rx_even),
    .rd_resync    (rd_resync),
    .state        (state),
    .err_level    (err_level),
    .loss_cnt     (loss_cnt)
  );

  always #5 rbc = ~rbc;

  task automatic model_reset();
    m_state = S_LOS; m_comma = 0; m_good = 0; m_err = 0; m_loss = 0;
    m_rx_even = 1'b0; m_resync = 1'b0;
  endtask

  task automatic model_step(input bit cv, sd, k, d, ce, re);
    int nxt;
    bit bad;
    bad      = ce || re || (k && m_rx_even);
    nxt      = m_state;
    m_resync = 1'b0;
    if (m_state != S_LOS && !sd) begin
      nxt = S_LOS;
    end else if (cv) begin
      m_rx_even = !m_rx_even;
      if (m_state == S_LOS) begin
        if (k) begin nxt = S_CDET; m_comma = 1; m_rx_even = 1'b1; end
      end else if (m_state == S_CDET) begin
        if (d && !bad) nxt = (m_comma >= COMMAS) ? S_SYNC : S_ACQ;
        else           nxt = S_LOS;
      end else if (m_state == S_ACQ) begin
        if (bad)    nxt = S_LOS;
        else if (k) begin nxt = S_CDET; m_comma++; m_rx_even = 1'b1; end
      end else begin
        if (bad) begin
          m_err++;
          m_good = 0;
          if (m_err >= ERRS) nxt = S_LOS;
        end else if (m_err > 0) begin
          m_good++;
          if (m_good == GOOD) begin m_err--; m_good = 0; end
        end
      end
    end
    if (nxt == S_LOS && m_state != S_LOS) begin
      m_resync = 1'b1;
      if (m_loss < 255) m_loss++;
      m_comma = 0; m_good = 0; m_err = 0;
    end
    m_state = nxt;
  endtask

  // Apply one cycle of inputs, advance the model at the edge, settle 1 time unit after it.
  task automatic drive(input bit cv, sd, k, d, ce, re);
    cg_valid = cv; signal_detect = sd; is_comma = k; is_data = d; code_err = ce; rd_err = re;
    @(posedge rbc);
    model_step(cv, sd, k, d, ce, re);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cg_valid = 1'b0; signal_detect = 1'b1; is_comma = 1'b0; is_data = 1'b0;
    code_err = 1'b0; rd_err = 1'b0;
    aresetn = 1'b0;
    model_reset();
    repeat (2) @(posedge rbc);
    #1 aresetn = 1'b1;
  endtask

  task automatic acquire();
    for (int i = 0; i < COMMAS; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle($urandom_range(0, 2));
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 3'd0)     begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (sync_ok !== 1'b0)   begin errors++; $display("FAIL reset_sync_ok: got %b want 0", sync_ok); end
    checks++; if (rx_even !== 1'b0)   begin errors++; $display("FAIL reset_rx_even: got %b want 0", rx_even); end
    checks++; if (rd_resync !== 1'b0) begin errors++; $display("FAIL reset_rd_resync: got %b want 0", rd_resync); end
    checks++; if (err_level !== 3'd0) begin errors++; $display("FAIL reset_err_level: got %0d want 0", err_level); end
    checks++; if (loss_cnt !== 8'd0)  begin errors++; $display("FAIL reset_loss_cnt: got %0d want 0", loss_cnt); end
  endtask

  task automatic test_acquire();
    do_reset();
    for (int i = 1; i <= COMMAS; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rx_even !== 1'b1 || sync_ok !== 1'b0 || state !== 3'd1) begin
        errors++; $display("FAIL acq_comma%0d: rx_even=%b sync_ok=%b state=%0d want 1 0 1", i, rx_even, sync_ok, state);
      end
      idle(i);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL acq_gap%0d: state=%0d want 1", i, state); end
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i < COMMAS) begin
        checks++; if (state !== 3'd2 || sync_ok !== 1'b0) begin
          errors++; $display("FAIL acq_data%0d: state=%0d sync_ok=%b want 2 0", i, state, sync_ok);
        end
      end else begin
        checks++; if (state !== 3'd3 || sync_ok !== 1'b1) begin
          errors++; $display("FAIL acq_sync: state=%0d sync_ok=%b want 3 1", state, sync_ok);
        end
      end
    end
    // Continued /I2/ stream must keep sync with comma on even positions
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (rx_even !== 1'b1 || state !== 3'd3 || err_level !== 3'd0) begin
        errors++; $display("FAIL idle_stream%0d: rx_even=%b state=%0d err=%0d want 1 3 0", i, rx_even, state, err_level);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_loss_rd_err();
    logic [2:0] want [7] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd0};
    do_reset();
    acquire();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, (i % 2) == 0);
      checks++; if (err_level !== want[i]) begin
        errors++; $display("FAIL loss_err_step%0d: got %0d want %0d", i, err_level, want[i]);
      end
      if (i < 6) begin
        checks++; if (sync_ok !== 1'b1 || rd_resync !== 1'b0) begin
          errors++; $display("FAIL loss_hold%0d: sync_ok=%b rd_resync=%b want 1 0", i, sync_ok, rd_resync);
        end
      end
    end
    checks++; if (state !== 3'd0 || sync_ok !== 1'b0 || rd_resync !== 1'b1 || loss_cnt !== 8'd1) begin
      errors++; $display("FAIL loss_event: state=%0d sync_ok=%b rd_resync=%b loss=%0d want 0 0 1 1", state, sync_ok, rd_resync, loss_cnt);
    end
    idle(1);
    checks++; if (rd_resync !== 1'b0 || loss_cnt !== 8'd1) begin
      errors++; $display("FAIL loss_pulse_end: rd_resync=%b loss=%0d want 0 1", rd_resync, loss_cnt);
    end
  endtask

  task automatic test_heal();
    logic [2:0] want [5] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    do_reset();
    acquire();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1, i == 0, 1'b0);
      checks++; if (err_level !== want[i] || sync_ok !== 1'b1) begin
        errors++; $display("FAIL heal_step%0d: err=%0d sync_ok=%b want %0d 1", i, err_level, sync_ok, want[i]);
      end
    end
  endtask

  task automatic test_odd_comma();
    do_reset();
    acquire();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (rx_even !== 1'b1) begin errors++; $display("FAIL odd_setup: rx_even=%b want 1", rx_even); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (err_level !== 3'd1 || state !== 3'd3) begin
      errors++; $display("FAIL odd_comma: err=%0d state=%0d want 1 3", err_level, state);
    end
  endtask

  task automatic test_sd_drop_acq();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL sd_setup: state=%0d want 2", state); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (state !== 3'd0 || rd_resync !== 1'b1 || loss_cnt !== 8'd1) begin
      errors++; $display("FAIL sd_drop: state=%0d rd_resync=%b loss=%0d want 0 1 1", state, rd_resync, loss_cnt);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (rd_resync !== 1'b0 || loss_cnt !== 8'd1) begin
      errors++; $display("FAIL sd_los_hold: rd_resync=%b loss=%0d want 0 1", rd_resync, loss_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    acquire();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (state !== 3'd0 || sync_ok !== 1'b0 || rd_resync !== 1'b1 || loss_cnt !== 8'd1) begin
      errors++; $display("FAIL sd_beats_good: state=%0d sync_ok=%b rd_resync=%b loss=%0d want 0 0 1 1", state, sync_ok, rd_resync, loss_cnt);
    end
    acquire();
    checks++; if (sync_ok !== 1'b1 || rd_resync !== 1'b0 || loss_cnt !== 8'd1) begin
      errors++; $display("FAIL reacquire: sync_ok=%b rd_resync=%b loss=%0d want 1 0 1", sync_ok, rd_resync, loss_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    acquire();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++; if (err_level !== 3'd2) begin errors++; $display("FAIL areset_setup: err=%0d want 2", err_level); end
    #2 aresetn = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || sync_ok !== 1'b0 || rx_even !== 1'b0 || rd_resync !== 1'b0 ||
                  err_level !== 3'd0 || loss_cnt !== 8'd0) begin
      errors++; $display("FAIL areset_async: state=%0d sync=%b rx_even=%b resync=%b err=%0d loss=%0d want all 0",
                         state, sync_ok, rx_even, rd_resync, err_level, loss_cnt);
    end
    model_reset();
    @(posedge rbc); #1;
    checks++; if (rd_resync !== 1'b0 || state !== 3'd0) begin
      errors++; $display("FAIL areset_no_pulse: rd_resync=%b state=%0d want 0 0", rd_resync, state);
    end
    aresetn = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 253) begin
        checks++; if (loss_cnt !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d want 254", loss_cnt); end
      end
    end
    checks++; if (loss_cnt !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d want 255", loss_cnt); end
  endtask

  task automatic test_random();
    bit cv, sd, k, d, ce, re;
    logic [16:0] exp_v, act_v;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cv = ($urandom_range(0, 99) < 85);
      sd = ($urandom_range(0, 199) != 0);
      k  = ($urandom_range(0, 9) < 1) ? 1'($urandom_range(0, 1)) : ((i % 2) == 0);
      d  = !k || ($urandom_range(0, 19) == 0);
      ce = ($urandom_range(0, 59) == 0);
      re = ($urandom_range(0, 59) == 0);
      drive(cv, sd, k, d, ce, re);
      exp_v = {3'(m_state), 3'(m_err), 8'(m_loss), (m_state == S_SYNC), m_rx_even, m_resync};
      act_v = {state, err_level, loss_cnt, sync_ok, rx_even, rd_resync};
      checks++; if (act_v !== exp_v) begin
        errors++;
        $display("FAIL random_cycle%0d: state/err/loss/sync/even/resync got %0d/%0d/%0d/%b/%b/%b want %0d/%0d/%0d/%b/%b/%b",
                 i, state, err_level, loss_cnt, sync_ok, rx_even, rd_resync,
                 m_state, m_err, m_loss, (m_state == S_SYNC), m_rx_even, m_resync);
      end
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_loss_rd_err();
    test_heal();
    test_odd_comma();
    test_sd_drop_acq();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
